// File: rtl/rc4_decrypt_ctrl.sv
// RC4 message-decrypt stage: XORs one PRGA keystream byte with each encrypted
// ROM byte, writes the plaintext to RAM and optionally aborts on illegal bytes.
module rc4_decrypt_ctrl #(
  parameter int MSG_LEN  = 32,
  parameter int ADDR_W   = 5,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              msg_ok,
  input  logic              ks_valid,
  input  logic [7:0]        ks_data,
  output logic              ks_ready,
  output logic              enc_rd_start,
  output logic [ADDR_W-1:0] enc_addr,
  input  logic              enc_rd_done,
  input  logic [7:0]        enc_rd_data,
  output logic              dec_wr_en,
  output logic [ADDR_W-1:0] dec_addr,
  output logic [7:0]        dec_wr_data
);

  typedef enum logic [2:0] {
    IDLE,
    KS_WAIT,
    ENC_REQ,
    ENC_WAIT,
    WRITE,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] k;
  logic [7:0]        ks_reg;
  logic [7:0]        p_reg;
  logic              msg_ok_r;
  logic              p_legal;
  logic              p_fail;

  // Legal alphabet for a plausible key: lowercase letters and space.
  assign p_legal = ((p_reg >= 8'h61) && (p_reg <= 8'h7A)) || (p_reg == 8'h20);
  assign p_fail  = CHECK_EN && !p_legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start) state_nxt = KS_WAIT;
      KS_WAIT:  if (ks_valid) state_nxt = ENC_REQ;
      ENC_REQ:  state_nxt = ENC_WAIT;
      ENC_WAIT: if (enc_rd_done) state_nxt = WRITE;
      WRITE:    state_nxt = (p_fail || (k == LAST_IDX)) ? DONE : KS_WAIT;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k        <= '0;
      ks_reg   <= '0;
      p_reg    <= '0;
      msg_ok_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            k        <= '0;
            msg_ok_r <= 1'b0;
          end
        end
        KS_WAIT: begin
          if (ks_valid) ks_reg <= ks_data;
        end
        ENC_WAIT: begin
          if (enc_rd_done) p_reg <= enc_rd_data ^ ks_reg;
        end
        WRITE: begin
          // An illegal byte is still written; it just ends the run with msg_ok low.
          if (p_fail) begin
            msg_ok_r <= 1'b0;
          end else if (k == LAST_IDX) begin
            msg_ok_r <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DONE);
    ks_ready     = (state == KS_WAIT);
    enc_rd_start = (state == ENC_REQ);
    dec_wr_en    = (state == WRITE);
    msg_ok       = msg_ok_r;
    enc_addr     = k;
    dec_addr     = k;
    dec_wr_data  = p_reg;
  end

endmodule

// File: tb/tb_rc4_decrypt_ctrl.sv
// Directed bench for rc4_decrypt_ctrl: instance 0 checks the alphabet,
// instance 1 decrypts without checking. MSG_LEN=4 for both.
module tb_rc4_decrypt_ctrl;

  localparam int N  = 2;
  localparam int AW = 5;
  localparam int ML = 4;

  logic          clk;
  logic          rst;
  logic          start        [N];
  logic          busy         [N];
  logic          done         [N];
  logic          msg_ok       [N];
  logic          ks_valid     [N];
  logic [7:0]    ks_data      [N];
  logic          ks_ready     [N];
  logic          enc_rd_start [N];
  logic [AW-1:0] enc_addr     [N];
  logic          resp_done    [N];
  logic          spur_done    [N];
  logic [7:0]    enc_rd_data  [N];
  logic          dec_wr_en    [N];
  logic [AW-1:0] dec_addr     [N];
  logic [7:0]    dec_wr_data  [N];

  logic [7:0]    rom [N][32];
  int            rd_delay [N] = '{1, 1};
  int            ks_delay [N] = '{0, 0};

  int            wr_cnt     [N] = '{default: 0};
  int            rd_cnt     [N] = '{default: 0};
  int            done_cnt   [N] = '{default: 0};
  int            ks_cnt     [N] = '{default: 0};
  int            ks_rdy_cyc [N] = '{default: 0};
  int            busy_cyc   [N] = '{default: 0};
  int            addr_err   [N] = '{default: 0};
  int            ks_drop    [N] = '{default: 0};
  logic          pend       [N] = '{default: 1'b0};
  logic [AW-1:0] pend_addr  [N];
  logic [AW-1:0] wr_addr_log [N][128];
  logic [7:0]    wr_data_log [N][128];
  logic [AW-1:0] rd_addr_log [N][128];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : gen_dut
    rc4_decrypt_ctrl #(
      .MSG_LEN (ML),
      .ADDR_W  (AW),
      .CHECK_EN(g == 0)
    ) u_dut (
      .clk         (clk),
      .reset       (rst),
      .start       (start[g]),
      .busy        (busy[g]),
      .done        (done[g]),
      .msg_ok      (msg_ok[g]),
      .ks_valid    (ks_valid[g]),
      .ks_data     (ks_data[g]),
      .ks_ready    (ks_ready[g]),
      .enc_rd_start(enc_rd_start[g]),
      .enc_addr    (enc_addr[g]),
      .enc_rd_done (resp_done[g] | spur_done[g]),
      .enc_rd_data (enc_rd_data[g]),
      .dec_wr_en   (dec_wr_en[g]),
      .dec_addr    (dec_addr[g]),
      .dec_wr_data (dec_wr_data[g])
    );

    // ROM responder: answers rd_delay cycles after the request, gives up on reset.
    initial begin : responder
      bit aborted;
      resp_done[g]   = 1'b0;
      enc_rd_data[g] = '0;
      forever begin
        @(negedge clk);
        if (enc_rd_start[g] && !rst) begin
          aborted = 1'b0;
          repeat (rd_delay[g]) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
          end
          if (!aborted) begin
            resp_done[g]   = 1'b1;
            enc_rd_data[g] = rom[g][enc_addr[g]];
            @(negedge clk);
            resp_done[g]   = 1'b0;
            enc_rd_data[g] = '0;
          end
        end
      end
    end

    // Keystream source: always valid when ks_delay==0, else withholds for ks_delay cycles.
    initial begin : ks_src
      ks_valid[g] = 1'b0;
      forever begin
        @(negedge clk);
        if (ks_delay[g] == 0) begin
          ks_valid[g] = 1'b1;
        end else if (ks_ready[g] && !ks_valid[g]) begin
          for (int i = 0; i < ks_delay[g]; i++) begin
            @(negedge clk);
            if (!ks_ready[g]) ks_drop[g]++;
          end
          ks_valid[g] = 1'b1;
        end else begin
          ks_valid[g] = 1'b0;
        end
      end
    end

    always @(negedge clk) begin
      if (dec_wr_en[g]) begin
        wr_addr_log[g][wr_cnt[g]] <= dec_addr[g];
        wr_data_log[g][wr_cnt[g]] <= dec_wr_data[g];
        wr_cnt[g]                 <= wr_cnt[g] + 1;
      end
      if (!busy[g] || dec_wr_en[g]) pend[g] <= 1'b0;
      if (enc_rd_start[g]) begin
        rd_addr_log[g][rd_cnt[g]] <= enc_addr[g];
        rd_cnt[g]                 <= rd_cnt[g] + 1;
        pend[g]                   <= 1'b1;
        pend_addr[g]              <= enc_addr[g];
      end else if (pend[g] && (enc_addr[g] !== pend_addr[g])) begin
        addr_err[g] <= addr_err[g] + 1;
      end
      if (done[g])                  done_cnt[g]   <= done_cnt[g] + 1;
      if (ks_valid[g] && ks_ready[g]) ks_cnt[g]   <= ks_cnt[g] + 1;
      if (ks_ready[g])              ks_rdy_cyc[g] <= ks_rdy_cyc[g] + 1;
      if (busy[g])                  busy_cyc[g]   <= busy_cyc[g] + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  task automatic kick(input int g);
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int d0);
    int c = 0;
    while ((done_cnt[g] == d0) && (c < 3000)) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (done_cnt[g] == d0) begin
      errors++;
      $display("FAIL done_timeout[%0d]: no done pulse after %0d cycles, required one", g, c);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      checks++;
      if ({busy[g], done[g], msg_ok[g], ks_ready[g], enc_rd_start[g], dec_wr_en[g],
           enc_addr[g], dec_addr[g], dec_wr_data[g]} !== 24'h0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got busy=%b done=%b ok=%b rdy=%b rs=%b we=%b ea=%0d da=%0d wd=%02h, required all 0",
                 g, busy[g], done[g], msg_ok[g], ks_ready[g], enc_rd_start[g], dec_wr_en[g],
                 enc_addr[g], dec_addr[g], dec_wr_data[g]);
      end
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b, required 0", busy[0]);
    end
  endtask

  task automatic test_full_pass();
    logic [7:0] exp_d [4] = '{8'h61, 8'h62, 8'h20, 8'h7A};
    int w0, r0, d0, b0;
    for (int i = 0; i < 4; i++) rom[0][i] = exp_d[i];
    ks_data[0]  = 8'h00;
    rd_delay[0] = 1;
    ks_delay[0] = 0;
    repeat (2) @(negedge clk);
    w0 = wr_cnt[0]; r0 = rd_cnt[0]; d0 = done_cnt[0]; b0 = busy_cyc[0];
    kick(0);
    wait_done(0, d0);
    checks++;
    if (wr_cnt[0] - w0 !== 4) begin
      errors++;
      $display("FAIL full_wr_count: got %0d, required 4", wr_cnt[0] - w0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({wr_addr_log[0][w0+i], wr_data_log[0][w0+i]} !== {5'(i), exp_d[i]}) begin
        errors++;
        $display("FAIL full_write[%0d]: got addr=%0d data=%02h, required addr=%0d data=%02h",
                 i, wr_addr_log[0][w0+i], wr_data_log[0][w0+i], i, exp_d[i]);
      end
    end
    checks++;
    if (done_cnt[0] - d0 !== 1) begin
      errors++;
      $display("FAIL full_done_count: got %0d, required 1", done_cnt[0] - d0);
    end
    checks++;
    if (msg_ok[0] !== 1'b1) begin
      errors++;
      $display("FAIL full_msg_ok: got %b, required 1", msg_ok[0]);
    end
    checks++;
    if (rd_cnt[0] - r0 !== 4) begin
      errors++;
      $display("FAIL full_rd_count: got %0d, required 4", rd_cnt[0] - r0);
    end
    checks++;
    if (busy_cyc[0] - b0 !== 17) begin
      errors++;
      $display("FAIL full_busy_cycles: got %0d, required 17", busy_cyc[0] - b0);
    end
  endtask

  task automatic test_early_abort();
    int w0, r0, d0, b0;
    rom[0][0] = 8'h9E; rom[0][1] = 8'hCF; rom[0][2] = 8'h9E; rom[0][3] = 8'h9E;
    ks_data[0] = 8'hFF;
    w0 = wr_cnt[0]; r0 = rd_cnt[0]; d0 = done_cnt[0]; b0 = busy_cyc[0];
    kick(0);
    wait_done(0, d0);
    checks++;
    if (wr_cnt[0] - w0 !== 2) begin
      errors++;
      $display("FAIL abort_wr_count: got %0d, required 2", wr_cnt[0] - w0);
    end
    checks++;
    if ({wr_addr_log[0][w0], wr_data_log[0][w0], wr_addr_log[0][w0+1], wr_data_log[0][w0+1]}
        !== {5'd0, 8'h61, 5'd1, 8'h30}) begin
      errors++;
      $display("FAIL abort_writes: got (%0d,%02h),(%0d,%02h), required (0,61),(1,30)",
               wr_addr_log[0][w0], wr_data_log[0][w0], wr_addr_log[0][w0+1], wr_data_log[0][w0+1]);
    end
    checks++;
    if (msg_ok[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_msg_ok: got %b, required 0", msg_ok[0]);
    end
    checks++;
    if ((rd_cnt[0] - r0 !== 2) || (rd_addr_log[0][r0+1] !== 5'd1)) begin
      errors++;
      $display("FAIL abort_reads: got %0d reads (last addr %0d), required 2 reads ending at 1",
               rd_cnt[0] - r0, rd_addr_log[0][r0+1]);
    end
    checks++;
    if ((done_cnt[0] - d0 !== 1) || (busy_cyc[0] - b0 !== 9)) begin
      errors++;
      $display("FAIL abort_timing: got done=%0d busy_cycles=%0d, required done=1 busy_cycles=9",
               done_cnt[0] - d0, busy_cyc[0] - b0);
    end
  endtask

  task automatic test_nocheck();
    logic [7:0] exp_d [4] = '{8'h61, 8'h30, 8'h61, 8'h30};
    int w0, d0;
    rom[1][0] = 8'h9E; rom[1][1] = 8'hCF; rom[1][2] = 8'h9E; rom[1][3] = 8'hCF;
    ks_data[1] = 8'hFF;
    w0 = wr_cnt[1]; d0 = done_cnt[1];
    kick(1);
    wait_done(1, d0);
    checks++;
    if (wr_cnt[1] - w0 !== 4) begin
      errors++;
      $display("FAIL nocheck_wr_count: got %0d, required 4", wr_cnt[1] - w0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({wr_addr_log[1][w0+i], wr_data_log[1][w0+i]} !== {5'(i), exp_d[i]}) begin
        errors++;
        $display("FAIL nocheck_write[%0d]: got addr=%0d data=%02h, required addr=%0d data=%02h",
                 i, wr_addr_log[1][w0+i], wr_data_log[1][w0+i], i, exp_d[i]);
      end
    end
    checks++;
    if (msg_ok[1] !== 1'b1) begin
      errors++;
      $display("FAIL nocheck_msg_ok: got %b, required 1", msg_ok[1]);
    end
  endtask

  task automatic test_handshake();
    logic [7:0] exp_d [4] = '{8'h61, 8'h62, 8'h20, 8'h7A};
    int w0, d0, b0, k0, y0, a0, s0;
    for (int i = 0; i < 4; i++) rom[0][i] = exp_d[i];
    ks_data[0]  = 8'h00;
    ks_delay[0] = 5;
    rd_delay[0] = 4;
    repeat (3) @(negedge clk);
    w0 = wr_cnt[0]; d0 = done_cnt[0]; b0 = busy_cyc[0];
    k0 = ks_cnt[0]; y0 = ks_rdy_cyc[0]; a0 = addr_err[0]; s0 = ks_drop[0];
    kick(0);
    wait_done(0, d0);
    checks++;
    if (ks_cnt[0] - k0 !== 4) begin
      errors++;
      $display("FAIL hs_ks_consumed: got %0d, required 4", ks_cnt[0] - k0);
    end
    checks++;
    if ((ks_rdy_cyc[0] - y0 !== 24) || (ks_drop[0] - s0 !== 0)) begin
      errors++;
      $display("FAIL hs_ks_ready: got %0d ready cycles, %0d drops, required 24 and 0",
               ks_rdy_cyc[0] - y0, ks_drop[0] - s0);
    end
    checks++;
    if (addr_err[0] - a0 !== 0) begin
      errors++;
      $display("FAIL hs_enc_addr_stable: got %0d changes, required 0", addr_err[0] - a0);
    end
    checks++;
    if (busy_cyc[0] - b0 !== 49) begin
      errors++;
      $display("FAIL hs_busy_cycles: got %0d, required 49", busy_cyc[0] - b0);
    end
    checks++;
    if ((wr_cnt[0] - w0 !== 4) || (wr_data_log[0][w0+3] !== 8'h7A) || (msg_ok[0] !== 1'b1)) begin
      errors++;
      $display("FAIL hs_result: got writes=%0d last=%02h ok=%b, required 4, 7a, 1",
               wr_cnt[0] - w0, wr_data_log[0][w0+3], msg_ok[0]);
    end
    // Spurious ks_valid (held high) and enc_rd_done in IDLE.
    ks_delay[0] = 0;
    rd_delay[0] = 1;
    repeat (2) @(negedge clk);
    w0 = wr_cnt[0]; b0 = busy_cyc[0];
    spur_done[0] = 1'b1;
    repeat (3) @(negedge clk);
    spur_done[0] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ((busy_cyc[0] - b0 !== 0) || (wr_cnt[0] - w0 !== 0) || (busy[0] !== 1'b0)) begin
      errors++;
      $display("FAIL idle_spurious: got busy_cycles=%0d writes=%0d busy=%b, required 0 0 0",
               busy_cyc[0] - b0, wr_cnt[0] - w0, busy[0]);
    end
  endtask

  task automatic test_restart_ignored();
    int w0, d0, b0, c;
    w0 = wr_cnt[0]; d0 = done_cnt[0]; b0 = busy_cyc[0];
    kick(0);
    c = 0;
    while (!(enc_rd_start[0] && (enc_addr[0] == 5'd2)) && (c < 200)) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c >= 200) begin
      errors++;
      $display("FAIL restart_reach_k2: no read of address 2 within %0d cycles, required one", c);
    end
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, d0);
    repeat (10) @(negedge clk);
    checks++;
    if ((done_cnt[0] - d0 !== 1) || (busy_cyc[0] - b0 !== 17)) begin
      errors++;
      $display("FAIL restart_single_run: got done=%0d busy_cycles=%0d, required 1 and 17",
               done_cnt[0] - d0, busy_cyc[0] - b0);
    end
    checks++;
    if ((wr_cnt[0] - w0 !== 4) || (msg_ok[0] !== 1'b1)) begin
      errors++;
      $display("FAIL restart_result: got writes=%0d ok=%b, required 4 and 1", wr_cnt[0] - w0, msg_ok[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int w0, d0, c;
    rd_delay[0] = 4;
    d0 = done_cnt[0];
    kick(0);
    c = 0;
    while (!(enc_rd_start[0] && (enc_addr[0] == 5'd1)) && (c < 200)) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c >= 200) begin
      errors++;
      $display("FAIL midreset_reach_k1: no read of address 1 within %0d cycles, required one", c);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy[0], done[0], msg_ok[0], ks_ready[0], enc_rd_start[0], dec_wr_en[0],
         enc_addr[0], dec_addr[0], dec_wr_data[0]} !== 24'h0) begin
      errors++;
      $display("FAIL midreset_async_outputs: got busy=%b ea=%0d da=%0d wd=%02h ok=%b, required all 0",
               busy[0], enc_addr[0], dec_addr[0], dec_wr_data[0], msg_ok[0]);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if ((done_cnt[0] - d0 !== 0) || (busy[0] !== 1'b0)) begin
      errors++;
      $display("FAIL midreset_no_done: got done=%0d busy=%b, required 0 and 0", done_cnt[0] - d0, busy[0]);
    end
    rd_delay[0] = 1;
    w0 = wr_cnt[0]; d0 = done_cnt[0];
    kick(0);
    wait_done(0, d0);
    checks++;
    if ((wr_cnt[0] - w0 !== 4) || (wr_addr_log[0][w0] !== 5'd0) || (wr_data_log[0][w0] !== 8'h61)
        || (msg_ok[0] !== 1'b1)) begin
      errors++;
      $display("FAIL midreset_rerun: got writes=%0d first=(%0d,%02h) ok=%b, required 4 (0,61) 1",
               wr_cnt[0] - w0, wr_addr_log[0][w0], wr_data_log[0][w0], msg_ok[0]);
    end
  endtask

  initial begin
    for (int g = 0; g < N; g++) begin
      start[g]     = 1'b0;
      spur_done[g] = 1'b0;
      ks_data[g]   = 8'h00;
      for (int i = 0; i < 32; i++) rom[g][i] = 8'h61;
    end
    test_reset();
    test_full_pass();
    test_early_abort();
    test_nocheck();
    test_handshake();
    test_restart_ignored();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
